// File: rtl/rsa_disp_pkg.sv
// Shared display definitions: converter states, mode symbol codes and
// active-low 7-segment glyphs (seg[6:0] = {G,F,E,D,C,B,A}).
package rsa_disp_pkg;

   typedef enum logic [1:0] {
      CONV_IDLE,
      CONV_SHIFT,
      CONV_COMMIT
   } conv_state_t;

   localparam logic [3:0] MODE_DASH = 4'hA;
   localparam logic [3:0] MODE_N    = 4'hB;
   localparam logic [3:0] MODE_C    = 4'hC;
   localparam logic [3:0] MODE_D    = 4'hD;
   localparam logic [3:0] MODE_E    = 4'hE;
   localparam logic [3:0] MODE_U    = 4'hF;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Codes 0-9 are decimal digits, A-F are the mode symbols.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] code);
      logic [6:0] glyph;
      case (code)
         4'h0:      glyph = 7'h40;
         4'h1:      glyph = 7'h79;
         4'h2:      glyph = 7'h24;
         4'h3:      glyph = 7'h30;
         4'h4:      glyph = 7'h19;
         4'h5:      glyph = 7'h12;
         4'h6:      glyph = 7'h02;
         4'h7:      glyph = 7'h78;
         4'h8:      glyph = 7'h00;
         4'h9:      glyph = 7'h10;
         MODE_DASH: glyph = SEG_DASH;
         MODE_N:    glyph = 7'h2B;
         MODE_C:    glyph = 7'h46;
         MODE_D:    glyph = 7'h21;
         MODE_E:    glyph = 7'h06;
         MODE_U:    glyph = 7'h41;
         default:   glyph = SEG_BLANK;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter. One bit per cycle;
// any carry out of the top nibble marks the result as not representable.
module bin2bcd_seq
   import rsa_disp_pkg::*;
#(
   parameter int KEY_W      = 32,
   parameter int BCD_DIGITS = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [KEY_W-1:0]        bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd,
   output logic                    ovf
);

   localparam int BW = 4 * BCD_DIGITS;
   localparam int CW = $clog2(KEY_W + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(KEY_W - 1);

   conv_state_t      state;
   logic [KEY_W-1:0] shreg;
   logic [BW-1:0]    work;
   logic [BW-1:0]    adj;
   logic [CW-1:0]    bit_cnt;
   logic             ovf_flag;

   // Add 3 to every nibble of 5 or more before the next shift.
   always_comb begin
      adj = work;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (work[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
         end
      end
   end

   // Converter FSM: capture, shift KEY_W bits, then publish the result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= CONV_IDLE;
         shreg    <= '0;
         work     <= '0;
         bit_cnt  <= '0;
         ovf_flag <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         ovf      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            CONV_IDLE: begin
               if (start) begin
                  shreg    <= bin;
                  work     <= '0;
                  bit_cnt  <= '0;
                  ovf_flag <= 1'b0;
                  busy     <= 1'b1;
                  state    <= CONV_SHIFT;
               end
            end
            CONV_SHIFT: begin
               work  <= {adj[BW-2:0], shreg[KEY_W-1]};
               shreg <= {shreg[KEY_W-2:0], 1'b0};
               if (adj[BW-1]) begin
                  ovf_flag <= 1'b1;
               end
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state <= CONV_COMMIT;
               end
            end
            CONV_COMMIT: begin
               bcd   <= work;
               ovf   <= ovf_flag;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= CONV_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= CONV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_display_ctrl.sv
// Multiplexed 7-segment driver: mode symbol, blank separator and an N-digit
// decimal key value with zero blanking, blinking cursor and overflow dashes.
module key_display_ctrl
   import rsa_disp_pkg::*;
#(
   parameter int KEY_W       = 32,
   parameter int BCD_DIGITS  = 10,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [3:0]                    mode_char,
   input  logic [KEY_W-1:0]              value,
   input  logic                          lz_blank,
   input  logic                          cursor_en,
   input  logic [$clog2(BCD_DIGITS)-1:0] cursor_pos,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [BCD_DIGITS+1:0]         anode,
   output logic                          conv_busy,
   output logic                          bcd_valid,
   output logic                          ovf
);

   localparam int NA  = BCD_DIGITS + 2;
   localparam int IW  = $clog2(NA);
   localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [IW-1:0]  MODE_IDX     = IW'(BCD_DIGITS + 1);
   localparam logic [IW-1:0]  SEP_IDX      = IW'(BCD_DIGITS);
   localparam logic [RW-1:0]  REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BLW-1:0] BLINK_LAST   = BLW'(BLINK_DIV - 1);

   logic                    conv_start;
   logic                    conv_run;
   logic                    conv_done;
   logic [4*BCD_DIGITS-1:0] conv_bcd;
   logic                    conv_ovf;
   logic [4*BCD_DIGITS-1:0] disp_buf;
   logic [KEY_W-1:0]        pending_val;
   logic [KEY_W-1:0]        last_converted;
   logic [RW-1:0]           refresh_cnt;
   logic [BLW-1:0]          blink_cnt;
   logic                    blink_on;
   logic [IW-1:0]           scan_idx;
   logic [NA-1:0]           next_anode;
   logic [6:0]              next_seg;
   logic                    next_dp;
   logic [3:0]              cur_digit;
   logic                    zero_run;
   logic                    lz_hit;
   logic                    cursor_hit;

   // A new conversion may only start once the previous result has landed.
   assign conv_start = !conv_run && !conv_done && (!bcd_valid || (value != last_converted));
   assign conv_busy  = conv_run | conv_done;

   bin2bcd_seq #(
      .KEY_W      (KEY_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .bin   (value),
      .busy  (conv_run),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   // Display buffer only changes on a finished conversion, so digits never tear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         disp_buf       <= '0;
         ovf            <= 1'b0;
         bcd_valid      <= 1'b0;
         pending_val    <= '0;
         last_converted <= '0;
      end else begin
         if (conv_start) begin
            pending_val <= value;
         end
         if (conv_done) begin
            disp_buf       <= conv_bcd;
            ovf            <= conv_ovf;
            bcd_valid      <= 1'b1;
            last_converted <= pending_val;
         end
      end
   end

   // Refresh divider steps the scan index; blink divider toggles the cursor phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
         blink_cnt   <= '0;
         blink_on    <= 1'b1;
      end else begin
         if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == MODE_IDX) ? '0 : scan_idx + 1'b1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Select the glyph for the current scan position, applying blanking rules.
   always_comb begin
      next_anode = '1;
      next_seg   = SEG_BLANK;
      next_dp    = 1'b1;
      cur_digit  = '0;
      zero_run   = 1'b1;
      lz_hit     = 1'b0;
      cursor_hit = 1'b0;
      for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (disp_buf[4*i +: 4] == 4'd0);
         if (int'(scan_idx) == i) begin
            cur_digit  = disp_buf[4*i +: 4];
            lz_hit     = zero_run && (i != 0) &&
                         !(cursor_en && (int'(cursor_pos) < BCD_DIGITS) && (i <= int'(cursor_pos)));
            cursor_hit = cursor_en && (int'(cursor_pos) == i);
         end
      end
      if (en) begin
         next_anode[scan_idx] = 1'b0;
         if (scan_idx == MODE_IDX) begin
            next_seg = digit_to_seg(mode_char);
            next_dp  = 1'b0;
         end else if (scan_idx == SEP_IDX) begin
            next_seg = SEG_BLANK;
         end else if (!bcd_valid) begin
            next_seg = SEG_BLANK;
         end else if (cursor_hit && !blink_on) begin
            next_seg = SEG_BLANK;
         end else if (ovf) begin
            next_seg = SEG_DASH;
         end else if (lz_blank && lz_hit) begin
            next_seg = SEG_BLANK;
         end else begin
            next_seg = digit_to_seg(cur_digit);
         end
      end
   end

   // Anode, segments and decimal point are registered together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         anode <= '1;
         seg   <= SEG_BLANK;
         dp    <= 1'b1;
      end else begin
         anode <= next_anode;
         seg   <= next_seg;
         dp    <= next_dp;
      end
   end

endmodule

// File: tb/tb_key_display_ctrl.sv
// Self-checking bench for key_display_ctrl: three instances cover the
// 10-digit display, a 3-digit overflow case and a drifting cursor blink.
module tb_key_display_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  mode_char;
   logic [31:0] value;
   logic        lz_blank;
   logic        cursor_en;
   logic [3:0]  cursor_pos;
   logic [11:0] b_value;

   logic [6:0]  a_seg, b_seg, c_seg;
   logic        a_dp, b_dp, c_dp;
   logic [11:0] a_anode, c_anode;
   logic [4:0]  b_anode;
   logic        a_busy, b_busy, c_busy;
   logic        a_valid, b_valid, c_valid;
   logic        a_ovf, b_ovf, c_ovf;

   int n_cmp = 0;
   int n_bad = 0;
   int tb_edges;

   typedef struct {
      int         pos;
      logic [6:0] seg;
      logic       dp;
   } frame_exp_t;

   frame_exp_t  exp_q[$];
   logic [39:0] val_q[$];

   logic [6:0] gly [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h2B, 7'h46, 7'h21, 7'h06, 7'h41};

   logic [6:0] obs_seg  [12];
   logic       obs_dp   [12];
   bit         obs_seen [12];

   int          sel = 0;
   logic [11:0] cap_anode;
   logic [6:0]  cap_seg;
   logic        cap_dp;
   logic        cap_busy;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) tb_edges <= 0;
      else      tb_edges <= tb_edges + 1;
   end

   always_comb begin
      case (sel)
         0:       begin cap_anode = a_anode;          cap_seg = a_seg; cap_dp = a_dp; cap_busy = a_busy; end
         1:       begin cap_anode = {7'h7F, b_anode}; cap_seg = b_seg; cap_dp = b_dp; cap_busy = b_busy; end
         default: begin cap_anode = c_anode;          cap_seg = c_seg; cap_dp = c_dp; cap_busy = c_busy; end
      endcase
   end

   key_display_ctrl #(.KEY_W(32), .BCD_DIGITS(10), .REFRESH_DIV(4), .BLINK_DIV(8)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode_char(mode_char), .value(value),
      .lz_blank(lz_blank), .cursor_en(cursor_en), .cursor_pos(cursor_pos),
      .seg(a_seg), .dp(a_dp), .anode(a_anode), .conv_busy(a_busy),
      .bcd_valid(a_valid), .ovf(a_ovf));

   key_display_ctrl #(.KEY_W(12), .BCD_DIGITS(3), .REFRESH_DIV(4), .BLINK_DIV(8)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode_char(mode_char), .value(b_value),
      .lz_blank(lz_blank), .cursor_en(1'b0), .cursor_pos(2'd0),
      .seg(b_seg), .dp(b_dp), .anode(b_anode), .conv_busy(b_busy),
      .bcd_valid(b_valid), .ovf(b_ovf));

   key_display_ctrl #(.KEY_W(32), .BCD_DIGITS(10), .REFRESH_DIV(3), .BLINK_DIV(8)) dut_c (
      .clk(clk), .rst(rst), .en(en), .mode_char(mode_char), .value(value),
      .lz_blank(lz_blank), .cursor_en(cursor_en), .cursor_pos(cursor_pos),
      .seg(c_seg), .dp(c_dp), .anode(c_anode), .conv_busy(c_busy),
      .bcd_valid(c_valid), .ovf(c_ovf));

   function automatic logic [39:0] to_bcd(input longint v);
      logic [39:0] r;
      longint      t;
      r = '0;
      t = v;
      for (int i = 0; i < 10; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int low_idx(input logic [11:0] a);
      int r;
      r = -1;
      for (int j = 0; j < 12; j++) begin
         if (!a[j]) r = (r == -1) ? j : -2;
      end
      return r;
   endfunction

   // Expected glyph per scan position for a committed value.
   task automatic push_frame(input int ndig, input longint v, input bit lz, input bit ovf_e,
                             input logic [3:0] mc, input int cpos, input int skip);
      int         d [10];
      longint     t;
      bit         allz;
      bit         protect;
      frame_exp_t e;
      t = v;
      for (int i = 0; i < 10; i++) begin
         d[i] = int'(t % 10);
         t = t / 10;
      end
      for (int i = 0; i < ndig; i++) begin
         if (i != skip) begin
            allz = 1'b1;
            for (int j = i; j < ndig; j++) if (d[j] != 0) allz = 1'b0;
            protect = (cpos >= 0) && (cpos < ndig) && (i <= cpos);
            e.pos = i;
            e.dp  = 1'b1;
            if (ovf_e)                                  e.seg = 7'h3F;
            else if (lz && (i != 0) && allz && !protect) e.seg = 7'h7F;
            else                                        e.seg = gly[d[i]];
            exp_q.push_back(e);
         end
      end
      e.pos = ndig;     e.seg = 7'h7F;   e.dp = 1'b1; exp_q.push_back(e);
      e.pos = ndig + 1; e.seg = gly[mc]; e.dp = 1'b0; exp_q.push_back(e);
   endtask

   task automatic capture_frame(input int s, input int npos, output bit timeout);
      int k;
      int seen_cnt;
      sel = s;
      seen_cnt = 0;
      for (int j = 0; j < 12; j++) obs_seen[j] = 1'b0;
      for (int cyc = 0; cyc < 400 && seen_cnt < npos; cyc++) begin
         @(negedge clk);
         k = low_idx(cap_anode);
         if (k >= 0 && k < npos && !obs_seen[k]) begin
            obs_seen[k] = 1'b1;
            obs_seg[k]  = cap_seg;
            obs_dp[k]   = cap_dp;
            seen_cnt++;
         end
      end
      timeout = (seen_cnt < npos);
   endtask

   task automatic wait_busy_cycles(input int s, output int busy_cycles, output bit timeout);
      sel = s;
      timeout = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 50 && !cap_busy; i++) @(negedge clk);
      if (!cap_busy) begin
         timeout = 1'b1;
      end else begin
         while (cap_busy && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge clk);
         end
         if (cap_busy) timeout = 1'b1;
      end
   endtask

   task automatic test_reset();
      int n;
      bit to;
      rst = 1'b0; en = 1'b1; mode_char = 4'hB; value = '0; lz_blank = 1'b0;
      cursor_en = 1'b0; cursor_pos = '0; b_value = '0;
      #22;
      n_cmp++; if (a_anode !== 12'hFFF) begin n_bad++; $display("[TB] FAIL reset_anode got %h want fff", a_anode); end
      n_cmp++; if (a_seg !== 7'h7F) begin n_bad++; $display("[TB] FAIL reset_seg got %h want 7f", a_seg); end
      n_cmp++; if (a_dp !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_dp got %b want 1", a_dp); end
      n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", a_busy); end
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid got %b want 0", a_valid); end
      n_cmp++; if (a_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ovf got %b want 0", a_ovf); end
      @(negedge clk);
      rst = 1'b1;
      wait_busy_cycles(0, n, to);
      n_cmp++; if (to || n != 34) begin n_bad++; $display("[TB] FAIL init_conv_len got %0d want 34 (timeout=%0b)", n, to); end
      n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL init_valid got %b want 1", a_valid); end
   endtask

   task automatic test_full_scale();
      int         n;
      bit         to;
      frame_exp_t e;
      logic [39:0] ev;
      @(negedge clk);
      value = 32'hFFFF_FFFF;
      lz_blank = 1'b0;
      val_q.push_back(to_bcd(64'd4294967295));
      push_frame(10, 64'd4294967295, 1'b0, 1'b0, 4'hB, -1, -1);
      wait_busy_cycles(0, n, to);
      n_cmp++; if (to || n != 34) begin n_bad++; $display("[TB] FAIL full_busy_len got %0d want 34 (timeout=%0b)", n, to); end
      n_cmp++; if (a_valid !== 1'b1 || a_ovf !== 1'b0) begin n_bad++; $display("[TB] FAIL full_flags got valid=%b ovf=%b want 1/0", a_valid, a_ovf); end
      ev = val_q.pop_front();
      n_cmp++; if (dut_a.disp_buf !== ev) begin n_bad++; $display("[TB] FAIL full_buffer got %h want %h", dut_a.disp_buf, ev); end
      repeat (2) @(negedge clk);
      capture_frame(0, 12, to);
      n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL full_capture got timeout want all 12 positions"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (!obs_seen[e.pos] || obs_seg[e.pos] !== e.seg || obs_dp[e.pos] !== e.dp) begin
            n_bad++;
            $display("[TB] FAIL full_pos%0d got seg=%h dp=%b want seg=%h dp=%b", e.pos, obs_seg[e.pos], obs_dp[e.pos], e.seg, e.dp);
         end
      end
   endtask

   task automatic test_overflow();
      int         n;
      bit         to;
      frame_exp_t e;
      lz_blank = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk);
         b_value = (pass == 0) ? 12'd1000 : 12'd999;
         push_frame(3, (pass == 0) ? 64'd1000 : 64'd999, 1'b1, (pass == 0), 4'hB, -1, -1);
         wait_busy_cycles(1, n, to);
         n_cmp++; if (to || n != 14) begin n_bad++; $display("[TB] FAIL ovf%0d_busy_len got %0d want 14", pass, n); end
         n_cmp++; if (b_ovf !== (pass == 0)) begin n_bad++; $display("[TB] FAIL ovf%0d_flag got %b want %0d", pass, b_ovf, pass == 0); end
         repeat (2) @(negedge clk);
         capture_frame(1, 5, to);
         n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL ovf%0d_capture got timeout want 5 positions", pass); end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (!obs_seen[e.pos] || obs_seg[e.pos] !== e.seg || obs_dp[e.pos] !== e.dp) begin
               n_bad++;
               $display("[TB] FAIL ovf%0d_pos%0d got seg=%h dp=%b want seg=%h dp=%b", pass, e.pos, obs_seg[e.pos], obs_dp[e.pos], e.seg, e.dp);
            end
         end
      end
   endtask

   task automatic test_scan_blanking();
      int         n, k, prev, dwell;
      bit         to, first;
      frame_exp_t e;
      @(negedge clk);
      value = 32'd42; lz_blank = 1'b1; cursor_en = 1'b0; mode_char = 4'hB;
      push_frame(10, 64'd42, 1'b1, 1'b0, 4'hB, -1, -1);
      wait_busy_cycles(0, n, to);
      n_cmp++; if (to || n != 34) begin n_bad++; $display("[TB] FAIL scan_busy_len got %0d want 34", n); end
      sel = 0; prev = -1; dwell = 0; first = 1'b1;
      for (int cyc = 0; cyc < 130; cyc++) begin
         @(negedge clk);
         k = low_idx(a_anode);
         if (k == prev) begin
            dwell++;
         end else begin
            if (prev >= 0 && !first) begin
               n_cmp++;
               if (k != (prev + 1) % 12 || dwell != 4) begin
                  n_bad++;
                  $display("[TB] FAIL scan_step got idx=%0d dwell=%0d want idx=%0d dwell=4", k, dwell, (prev + 1) % 12);
               end
            end
            if (prev >= 0) first = 1'b0;
            prev = k;
            dwell = 1;
         end
      end
      capture_frame(0, 12, to);
      n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL scan_capture got timeout want 12 positions"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (!obs_seen[e.pos] || obs_seg[e.pos] !== e.seg || obs_dp[e.pos] !== e.dp) begin
            n_bad++;
            $display("[TB] FAIL scan_pos%0d got seg=%h dp=%b want seg=%h dp=%b", e.pos, obs_seg[e.pos], obs_dp[e.pos], e.seg, e.dp);
         end
      end
   endtask

   task automatic test_cursor();
      bit         to, on;
      int         on_seen, off_seen;
      logic [6:0] want;
      frame_exp_t e;
      @(negedge clk);
      cursor_en = 1'b1; cursor_pos = 4'd4; lz_blank = 1'b1;
      repeat (2) @(negedge clk);
      push_frame(10, 64'd42, 1'b1, 1'b0, 4'hB, 4, 4);
      capture_frame(2, 12, to);
      n_cmp++; if (to) begin n_bad++; $display("[TB] FAIL cursor_capture got timeout want 12 positions"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (!obs_seen[e.pos] || obs_seg[e.pos] !== e.seg || obs_dp[e.pos] !== e.dp) begin
            n_bad++;
            $display("[TB] FAIL cursor_pos%0d got seg=%h dp=%b want seg=%h dp=%b", e.pos, obs_seg[e.pos], obs_dp[e.pos], e.seg, e.dp);
         end
      end
      on_seen = 0; off_seen = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (c_anode[4] === 1'b0) begin
            on = (((tb_edges - 1) / 8) % 2) == 0;
            want = on ? gly[0] : 7'h7F;
            if (on) on_seen++; else off_seen++;
            n_cmp++;
            if (c_seg !== want) begin
               n_bad++;
               $display("[TB] FAIL cursor_blink got seg=%h want %h at edge %0d", c_seg, want, tb_edges);
            end
         end
      end
      n_cmp++;
      if (on_seen == 0 || off_seen == 0) begin
         n_bad++;
         $display("[TB] FAIL cursor_phases got on=%0d off=%0d want both nonzero", on_seen, off_seen);
      end
      @(negedge clk);
      cursor_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      int          n;
      bit          to;
      logic [39:0] ev;
      @(negedge clk);
      value = 32'd5;
      val_q.push_back(to_bcd(64'd5));
      val_q.push_back(to_bcd(64'd7));
      sel = 0;
      for (int i = 0; i < 50 && !a_busy; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      value = 32'd7;
      n = 0;
      while (a_busy && n < 200) begin n++; @(negedge clk); end
      ev = val_q.pop_front();
      n_cmp++; if (a_busy || dut_a.disp_buf !== ev) begin n_bad++; $display("[TB] FAIL b2b_first got %h want %h", dut_a.disp_buf, ev); end
      wait_busy_cycles(0, n, to);
      n_cmp++; if (to || n != 34) begin n_bad++; $display("[TB] FAIL b2b_second_len got %0d want 34", n); end
      ev = val_q.pop_front();
      n_cmp++; if (dut_a.disp_buf !== ev) begin n_bad++; $display("[TB] FAIL b2b_second got %h want %h", dut_a.disp_buf, ev); end
   endtask

   task automatic test_enable();
      bit saw_busy;
      @(negedge clk);
      en = 1'b0;
      value = 32'd1234;
      saw_busy = 1'b0;
      repeat (2) @(negedge clk);
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         if (a_busy) saw_busy = 1'b1;
         n_cmp++;
         if (a_anode !== 12'hFFF || a_seg !== 7'h7F || a_dp !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL en_off got anode=%h seg=%h dp=%b want fff/7f/1", a_anode, a_seg, a_dp);
         end
      end
      n_cmp++; if (!saw_busy) begin n_bad++; $display("[TB] FAIL en_off_conv got busy never seen want busy while disabled"); end
      en = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (low_idx(a_anode) < 0) begin n_bad++; $display("[TB] FAIL en_on got anode=%h want one-hot-low", a_anode); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      value = 32'd99;
      for (int i = 0; i < 50 && !a_busy; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_cmp++; if (!a_busy || a_anode === 12'hFFF) begin n_bad++; $display("[TB] FAIL areset_pre got busy=%b anode=%h want 1/active", a_busy, a_anode); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++; if (a_anode !== 12'hFFF) begin n_bad++; $display("[TB] FAIL areset_anode got %h want fff", a_anode); end
      n_cmp++; if (a_seg !== 7'h7F) begin n_bad++; $display("[TB] FAIL areset_seg got %h want 7f", a_seg); end
      n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_busy got %b want 0", a_busy); end
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL areset_valid got %b want 0", a_valid); end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog got no finish want finish before 1000000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_full_scale();
      test_overflow();
      test_scan_blanking();
      test_cursor();
      test_back_to_back();
      test_enable();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/key_display_ctrl.md
Name: key_display_ctrl

Overview:
Parametrised successor of the key display path: registered multiplexed 7-segment driver for a mode character plus an N-digit decimal key value.
- Converts the binary key value to BCD sequentially (shift-and-add-3), not combinationally.
- Adds leading-zero blanking, a blinking edit cursor, overflow indication and double-buffered, tear-free display updates.
- Sits between KeyManager/top-level mode logic and the board display pins.

Parameters:
- KEY_W, 32, key value width in bits.
- BCD_DIGITS, 10, number of decimal value digits (anode count = BCD_DIGITS+2).
- REFRESH_DIV, 100000, clk cycles each anode stays active (>=1).
- BLINK_DIV, 25000000, clk cycles per cursor blink half-period (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  display enable; 0 blanks all anodes.
- mode_char  input  4  mode symbol code.
- value  input  KEY_W  binary key to display.
- lz_blank  input  1  1 = blank leading zeros.
- cursor_en  input  1  1 = blink the digit at cursor_pos.
- cursor_pos  input  $clog2(BCD_DIGITS)  cursor digit index; 0 = least significant.
- seg  output  7  segments A..G, active-low.
- dp  output  1  decimal point, active-low.
- anode  output  BCD_DIGITS+2  digit enables, active-low, one-hot-low.
- conv_busy  output  1  conversion in progress.
- bcd_valid  output  1  display buffer holds at least one completed conversion.
- ovf  output  1  last value did not fit in BCD_DIGITS.

Behaviour:
- Reset (rst=0, async): anode all 1, seg 7'h7F, dp 1, conv_busy 0, bcd_valid 0, ovf 0, display buffer 0, scan index 0, refresh and blink counters 0, blink phase on, converter IDLE.
- Converter FSM, IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: if value != last_converted, or bcd_valid=0, capture value and enter SHIFT.
  - SHIFT: KEY_W iterations. Each cycle, add 3 to every BCD nibble >= 5, then shift left 1 bit, taking in the value MSB.
  - Any 1 shifted out of the top nibble sets a sticky internal overflow flag.
  - COMMIT: copy the BCD result to the display buffer, set ovf from the flag, set bcd_valid=1, store last_converted.
  - Latency from capture to updated buffer: KEY_W+2 cycles. conv_busy=1 in SHIFT and COMMIT.
  - value changing mid-conversion: the current conversion completes and commits; the new value is captured at the next IDLE cycle.
  - Display always shows the last committed buffer, never intermediate digits.
- Scan:
  - The refresh counter wraps at REFRESH_DIV-1; on wrap the scan index increments, wrapping from BCD_DIGITS+1 to 0.
  - Index BCD_DIGITS+1: mode character, dp=0.
  - Index BCD_DIGITS: blank separator.
  - Index i < BCD_DIGITS: BCD digit i, dp=1.
  - anode, seg and dp are registered and update on the same edge.
- Mode char glyphs: 0-9 decimal, a '-', b 'n', c 'C', d 'd', e 'E', f 'U'.
- ovf=1: every value digit shows '-'; the cursor still blinks.
- Leading-zero blanking (lz_blank=1): digit i is blanked if it and all digits above it are 0.
  - Digit 0 is never blanked.
  - The cursor digit and all digits below it are never zero-blanked.
- Cursor: the blink counter wraps at BLINK_DIV-1 and toggles the phase on wrap. With cursor_en=1 in the off phase, digit cursor_pos is blanked (seg 7'h7F).
- cursor_pos >= BCD_DIGITS: no digit is affected.
- en=0: anode all 1, seg/dp off. Conversion and counters keep running.
- bcd_valid=0: value digits show blank; the mode char is still shown.

Decomposition:
- Shared package rsa_disp_pkg: mode char codes, 7-segment glyph constants (active-low), blank/dash constants, function digit_to_seg.
- One natural sub-module: bin2bcd_seq (parameters KEY_W, BCD_DIGITS; ports start, bin, busy, done, bcd, ovf).
- Scan, blanking and glyph mux stay in key_display_ctrl.

Test Plan:
- Reset: assert rst=0 mid-scan and mid-SHIFT -> anode=all 1, seg=7'h7F, conv_busy=0, bcd_valid=0 immediately, without a clk edge.
- Full-scale conversion: value=32'hFFFFFFFF -> conv_busy high for 34 cycles; buffer digits 9..0 = 4,2,9,4,9,6,7,2,9,5; bcd_valid=1; ovf=0.
- Overflow: BCD_DIGITS=3, value=1000 -> ovf=1, three value digits show '-' (seg=7'h3F); then value=999 -> ovf=0, digits 9,9,9.
- Scan and blanking: REFRESH_DIV=4, value=42, lz_blank=1, mode_char=b -> anode low bit rotates every 4 cycles through 12 positions and wraps; only digits 0-1 lit ('2','4'); mode position shows 'n' with dp=0.
- Cursor: BLINK_DIV=8, lz_blank=1, value=42, cursor_en=1, cursor_pos=4 -> digits 4..0 show 0,0,0,4,2; digit 4 blanked on alternate 8-cycle phases.
- Mid-conversion change and enable: change value 5->7 during SHIFT -> buffer commits 5, then 7 after a further KEY_W+2 cycles; en=0 -> anodes all 1 while conv_busy continues toggling.
